serial_tx: RTL
==============

Name: serial_tx

Overview:
- Serial transmitter built from the team's flip-flop and counter primitives; the sending end of the lab's single-wire serial link.
- Accepts a parallel word over a valid/ready handshake.
- Emits a framed serial stream on one output: start bit, data bits LSB first, optional parity bit, stop bit.
- Bit timing comes from an internal clock-cycle divider; a clock-enable freezes all progress.

Parameters:
- DATA_W, 8, data bits per frame (legal range 1..16).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (legal range >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; 0 holds every register, including the divider, state, shift register and tx.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  word on tx_data is offered.
- tx_ready  output  1  transmitter can accept a word.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst=1 at a rising edge): tx=1, tx_ready=1, busy=0, state IDLE, divider=0, bit index=0. rst takes priority over en.
- States: IDLE, START, DATA, PARITY (feature only), STOP.
- Handshake: a word is accepted at a rising edge where tx_valid=1, tx_ready=1 and en=1.
  - At that edge: latch tx_data into the shift register, go to START, set tx=0, busy=1, tx_ready=0.
  - tx_valid=1 with tx_ready=0 is ignored; the source must hold the word.
- tx_ready=1 only in IDLE. Combinationally, tx_ready = (state==IDLE) && !rst.
- Divider counts 0..CLKS_PER_BIT-1 on enabled cycles. Counter width is $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Each bit occupies exactly CLKS_PER_BIT enabled cycles.
  - The bit advances when divider==CLKS_PER_BIT-1, and the divider then wraps to 0.
- START: tx=0 for one bit time, then DATA with bit index 0.
- DATA: tx=shift_reg[0]; shift right at each bit boundary.
  - After bit index DATA_W-1 completes, go to STOP (or PARITY when the feature is enabled).
- STOP: tx=1 for one bit time, then IDLE. busy=0 and tx_ready=1 from the following edge.
- Frame length, feature off: (DATA_W+2)*CLKS_PER_BIT enabled cycles, counted from the acceptance edge to the return to IDLE.
- Back-to-back frames: a word offered during STOP is accepted at the first edge in IDLE. The resulting idle gap between frames is one clock cycle, with tx=1.
- CLKS_PER_BIT=1: every state lasts one enabled cycle; the divider is constant 0.
- tx_data changes while busy have no effect on the frame in flight.
- Reset mid-frame: frame abandoned. tx=1 and all outputs return to reset values at that edge; no partial stop bit is sent.
- en=0 mid-frame: tx holds its current bit level; the frame resumes exactly where it stopped when en returns to 1.
- All outputs are registered except tx_ready.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting one bit time.
  - tx = even parity (XOR of the accepted word), computed at acceptance.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity register.

Test Plan:
- Reset: rst=1 for 2 cycles -> tx=1, tx_ready=1, busy=0. tx_valid=1 during reset is not accepted.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, tx_data=8'hA5:
  - tx sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles; tx_ready returns high on cycle 40 after acceptance.
- Back-to-back 8'h00 then 8'hFF with tx_valid held high -> second start bit begins 1 cycle after the first frame's stop bit ends. Data bits are all 0, then all 1.
- en gating: with 8'h3C in flight, drop en for 7 cycles mid-DATA -> tx frozen at the current bit; total frame spans 47 cycles; bit pattern unchanged.
- Reset mid-frame: assert rst during data bit 3 of 8'h55 -> tx=1 and tx_ready=1 at that edge. A fresh 8'h81 then transmits correctly.
- With SERIAL_TX_PARITY_EN defined, tx_data=8'h07 -> parity bit 1 before the stop bit; frame is 44 cycles. tx_data=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter (start, DATA_W bits LSB first, optional even parity, stop).
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t            state_q, state_d;
  logic [CW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  assign tick     = div_q == CW'(CLKS_PER_BIT - 1);
  assign tx_ready = (state_q == IDLE) && !rst;
  assign tx       = tx_q;
  assign busy     = busy_q;
  // Next-state logic: the divider paces every non-idle state; the bit advances on its wrap.
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE) ? '0 : (tick ? '0 : div_q + CW'(1));
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = START;
        shift_d = tx_data;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = ^tx_data;
`endif
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = shift_q[0];
        idx_d   = '0;
      end
      DATA: if (tick) begin
        if (idx_q == IW'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + IW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_d[0];
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
  // State registers: reset wins over enable; en=0 freezes everything including the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (en) begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule
